uart_seq_tst: RTL and testbench

UART_SEQ_TST -- requirements
Module: uart_seq_tst

---
 rtl/uart_tst_pkg.sv | 32 +++
 rtl/uart_timeout_cnt.sv | 39 +++
 rtl/uart_seq_tst.sv | 194 +++++++++++++++++++
 tb/tb_uart_seq_tst.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tst_pkg.sv
// Shared state codes and default parameters for the UART sequence tester.
package uart_tst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_ARM     = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_WAIT_RX = 3'd4,
    ST_CHECK   = 3'd5,
    ST_HALT    = 3'd6
  } state_e;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_START_VAL   = 65;
  localparam int DEF_ECHO_INC    = 1;
  localparam int DEF_TIMEOUT_CYC = 1_000_000;
  localparam int DEF_MAX_ERR     = 255;

  localparam int LEDS_W  = 10;
  localparam int ERR_LED = 9;

  function automatic logic [LEDS_W-1:0] state_leds(input state_e s, input logic err);
    logic [LEDS_W-1:0] l;
    l          = '0;
    l[s]       = 1'b1;
    l[ERR_LED] = err;
    return l;
  endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Receive-wait counter: clears on request, counts while enabled, flags TIMEOUT_CYC-1.
module uart_timeout_cnt
  import uart_tst_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc = (count_q == TC_VAL);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_seq_tst.sv
// UART sequence tester: echoes host bytes (mode 0) or runs an incrementing
// loopback self-test (mode 1), counting passes, mismatches and timeouts.
module uart_seq_tst
  import uart_tst_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int START_VAL   = DEF_START_VAL,
  parameter int ECHO_INC    = DEF_ECHO_INC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int MAX_ERR     = DEF_MAX_ERR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              timeout,
  output logic              halted,
  output logic [3:0]        svn_seg_0,
  output logic [LEDS_W-1:0] states_leds
);

  state_e              state_q, state_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [DATA_W-1:0]   nxt_byte_q, nxt_byte_d;
  logic                mode_q, mode_d;
  logic                rx_flag_q, rx_flag_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                to_pend_q, to_pend_d;
  logic [CNT_W-1:0]    pass_q, pass_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic                timeout_q, timeout_d;
  logic                err_led_q, err_led_d;
  logic                halted_q, halted_d;
  logic [3:0]          seg_q, seg_d;
  logic [LEDS_W-1:0]   leds_q, leds_d;
  logic                wait_tc;
  logic                wait_clr;
  logic                wait_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  uart_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_cnt (
    .clk(clk),
    .rst(rst),
    .clr(wait_clr),
    .en (wait_en),
    .tc (wait_tc)
  );

  assign wait_clr = (state_d == ST_WAIT_RX) && (state_q != ST_WAIT_RX);
  assign wait_en  = (state_q == ST_WAIT_RX);

  // Receive capture runs independently of the FSM; a new byte landing in the
  // clearing cycle wins over the clear.
  always_comb begin
    hold_d    = rx_ready ? rx_data : hold_q;
    rx_flag_d = rx_flag_q;
    if (rx_ready) begin
      rx_flag_d = 1'b1;
    end else if (state_q == ST_CHECK) begin
      rx_flag_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    nxt_byte_d = nxt_byte_q;
    mode_d     = mode_q;
    to_pend_d  = to_pend_q;
    pass_d     = pass_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    err_led_d  = err_led_q;
    if (!en && state_q != ST_HALT) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mode_d = mode;
          if (mode) begin
            state_d   = ST_SEND;
            tx_data_d = nxt_byte_q;
          end else begin
            state_d = ST_WAIT_RX;
          end
        end
        ST_SEND:    state_d = ST_ARM;
        ST_ARM:     state_d = ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (!tx_busy) state_d = mode_q ? ST_WAIT_RX : ST_IDLE;
        end
        ST_WAIT_RX: begin
          if (rx_flag_q) begin
            state_d   = ST_CHECK;
            to_pend_d = 1'b0;
          end else if (wait_tc) begin
            state_d   = ST_CHECK;
            to_pend_d = 1'b1;
          end
        end
        ST_CHECK: begin
          if (to_pend_q) begin
            // nxt_byte is left untouched so loopback resends the same byte
            err_d     = sat_inc(err_q);
            timeout_d = 1'b1;
            err_led_d = 1'b1;
            state_d   = mode_q ? ST_SEND : ST_IDLE;
          end else if (!mode_q) begin
            tx_data_d = hold_q + DATA_W'(ECHO_INC);
            pass_d    = sat_inc(pass_q);
            state_d   = ST_SEND;
          end else begin
            if (hold_q == tx_data_q) begin
              pass_d = sat_inc(pass_q);
            end else begin
              err_d     = sat_inc(err_q);
              err_led_d = 1'b1;
            end
            nxt_byte_d = nxt_byte_q + 1'b1;
            tx_data_d  = nxt_byte_q + 1'b1;
            state_d    = ST_SEND;
          end
          if (64'(err_d) >= 64'(MAX_ERR)) state_d = ST_HALT;
        end
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_IDLE;
      endcase
    end
    tx_start_d = (state_d == ST_SEND);
    halted_d   = (state_d == ST_HALT);
    seg_d      = {1'b0, state_d};
    leds_d     = state_leds(state_d, err_led_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      nxt_byte_q <= DATA_W'(START_VAL);
      mode_q     <= 1'b0;
      rx_flag_q  <= 1'b0;
      hold_q     <= '0;
      to_pend_q  <= 1'b0;
      pass_q     <= '0;
      err_q      <= '0;
      timeout_q  <= 1'b0;
      err_led_q  <= 1'b0;
      halted_q   <= 1'b0;
      seg_q      <= 4'd0;
      leds_q     <= LEDS_W'(1);
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      nxt_byte_q <= nxt_byte_d;
      mode_q     <= mode_d;
      rx_flag_q  <= rx_flag_d;
      hold_q     <= hold_d;
      to_pend_q  <= to_pend_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      err_led_q  <= err_led_d;
      halted_q   <= halted_d;
      seg_q      <= seg_d;
      leds_q     <= leds_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign pass_cnt    = pass_q;
  assign err_cnt     = err_q;
  assign timeout     = timeout_q;
  assign halted      = halted_q;
  assign svn_seg_0   = seg_q;
  assign states_leds = leds_q;

endmodule

// File: tb/tb_uart_seq_tst.sv
// Bench for uart_seq_tst: directed scenarios plus randomized echo/loopback runs.
module tb_uart_seq_tst;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       en_b = 1'b0;
  logic       mode = 1'b0;
  logic       rx_ready = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] rx_data_b = 8'h00;

  logic        tx_start, tx_start_b;
  logic [7:0]  tx_data, tx_data_b;
  logic [15:0] pass_cnt, pass_cnt_b, err_cnt, err_cnt_b;
  logic        timeout, timeout_b, halted, halted_b;
  logic [3:0]  svn, svn_b;
  logic [9:0]  leds, leds_b;

  int checks = 0;
  int errors = 0;
  int txa_cnt = 0;
  int txb_cnt = 0;

  always #5 clk = ~clk;

  uart_seq_tst #(.TIMEOUT_CYC(TO), .MAX_ERR(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .pass_cnt(pass_cnt),
    .err_cnt(err_cnt), .timeout(timeout), .halted(halted), .svn_seg_0(svn), .states_leds(leds)
  );

  uart_seq_tst #(.START_VAL(255), .TIMEOUT_CYC(TO), .MAX_ERR(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode), .rx_ready(rx_ready), .rx_data(rx_data_b),
    .tx_busy(tx_busy), .tx_start(tx_start_b), .tx_data(tx_data_b), .pass_cnt(pass_cnt_b),
    .err_cnt(err_cnt_b), .timeout(timeout_b), .halted(halted_b), .svn_seg_0(svn_b),
    .states_leds(leds_b)
  );

  always @(negedge clk) begin
    if (tx_start === 1'b1) txa_cnt++;
    if (tx_start_b === 1'b1) txb_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; en_b = 1'b0; rx_ready = 1'b0; tx_busy = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_tx(input bit b, input int budget, output bit ok, output logic [7:0] d);
    ok = 1'b0;
    d  = 8'h00;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if ((b ? tx_start_b : tx_start) === 1'b1) begin
        ok = 1'b1;
        d  = b ? tx_data_b : tx_data;
        break;
      end
    end
  endtask

  // Plays the transmitter and, optionally, the far end returning resp.
  task automatic serve(input int busy_n, input bit do_rx, input logic [7:0] resp, input bit b);
    tx_busy = 1'b1;
    tick(busy_n);
    tx_busy = 1'b0;
    if (do_rx) begin
      tick(2);
      if (b) rx_data_b = resp; else rx_data = resp;
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %0b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %0h want 0", tx_data); end
    checks++; if (pass_cnt !== 16'd0) begin errors++; $display("FAIL rst_pass got %0d want 0", pass_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err got %0d want 0", err_cnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b want 0", timeout); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %0b want 0", halted); end
    checks++; if (svn !== 4'd0) begin errors++; $display("FAIL rst_svn got %0d want 0", svn); end
    checks++; if (leds !== 10'b1) begin errors++; $display("FAIL rst_leds got %b want 0000000001", leds); end
  endtask

  task automatic test_loopback_basic();
    bit ok;
    logic [7:0] d, e;
    do_reset();
    mode = 1'b1; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = 8'(65 + k);
      wait_tx(1'b0, 40, ok, d);
      checks++; if (!ok || d !== e) begin errors++; $display("FAIL lb_byte%0d got %0h ok=%0b want %0h", k, d, ok, e); end
      serve(10, 1'b1, d, 1'b0);
    end
    wait_tx(1'b0, 60, ok, d);
    checks++; if (!ok || d !== 8'h44) begin errors++; $display("FAIL lb_byte3 got %0h ok=%0b want 44", d, ok); end
    checks++; if (pass_cnt !== 16'd3) begin errors++; $display("FAIL lb_pass got %0d want 3", pass_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL lb_err got %0d want 0", err_cnt); end
    en = 1'b0;
    tick(2);
    checks++; if (svn !== 4'd0) begin errors++; $display("FAIL lb_park got %0d want 0", svn); end
  endtask

  task automatic test_echo();
    bit ok;
    logic [7:0] d;
    int base;
    do_reset();
    mode = 1'b0; en = 1'b1;
    tick(2);
    checks++; if (svn !== 4'd4) begin errors++; $display("FAIL echo_wait_rx got %0d want 4", svn); end
    mode = 1'b1;
    base = txa_cnt;
    rx_data = 8'h30; rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    wait_tx(1'b0, 20, ok, d);
    checks++; if (!ok || d !== 8'h31) begin errors++; $display("FAIL echo_data got %0h ok=%0b want 31", d, ok); end
    tx_busy = 1'b1;
    tick(10);
    tx_busy = 1'b0;
    tick(1);
    checks++; if (svn !== 4'd0) begin errors++; $display("FAIL echo_idle got %0d want 0", svn); end
    checks++; if (txa_cnt - base !== 1) begin errors++; $display("FAIL echo_one_start got %0d want 1", txa_cnt - base); end
    checks++; if (pass_cnt !== 16'd1) begin errors++; $display("FAIL echo_pass got %0d want 1", pass_cnt); end
    wait_tx(1'b0, 10, ok, d);
    checks++; if (!ok || d !== 8'h41) begin errors++; $display("FAIL echo_mode_switch got %0h ok=%0b want 41", d, ok); end
    en = 1'b0;
    tick(3);
  endtask

  task automatic test_timeout();
    bit ok;
    logic [7:0] d;
    do_reset();
    mode = 1'b1; en = 1'b1;
    wait_tx(1'b0, 20, ok, d);
    checks++; if (!ok || d !== 8'h41) begin errors++; $display("FAIL to_first got %0h ok=%0b want 41", d, ok); end
    serve(5, 1'b0, 8'h00, 1'b0);
    wait_tx(1'b0, TO + 30, ok, d);
    checks++; if (!ok || d !== 8'h41) begin errors++; $display("FAIL to_resend got %0h ok=%0b want 41", d, ok); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL to_err got %0d want 1", err_cnt); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %0b want 1", timeout); end
    checks++; if (pass_cnt !== 16'd0) begin errors++; $display("FAIL to_pass got %0d want 0", pass_cnt); end
    checks++; if (leds[9] !== 1'b1) begin errors++; $display("FAIL to_led9 got %0b want 1", leds[9]); end
    en = 1'b0;
    tick(2);
  endtask

  task automatic test_halt();
    bit ok;
    logic [7:0] d;
    int base;
    do_reset();
    mode = 1'b1; en = 1'b1;
    wait_tx(1'b0, 20, ok, d);
    serve(3, 1'b1, ~d, 1'b0);
    wait_tx(1'b0, 20, ok, d);
    checks++; if (!ok || d !== 8'h42) begin errors++; $display("FAIL halt_next got %0h ok=%0b want 42", d, ok); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL halt_err1 got %0d want 1", err_cnt); end
    serve(3, 1'b1, ~d, 1'b0);
    tick(3);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %0b want 1", halted); end
    checks++; if (svn !== 4'd6) begin errors++; $display("FAIL halt_svn got %0d want 6", svn); end
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL halt_err2 got %0d want 2", err_cnt); end
    base = txa_cnt;
    en = 1'b0;
    tick(20);
    en = 1'b1;
    tick(20);
    checks++; if (svn !== 4'd6) begin errors++; $display("FAIL halt_sticky got %0d want 6", svn); end
    checks++; if (txa_cnt !== base) begin errors++; $display("FAIL halt_no_tx got %0d want %0d", txa_cnt, base); end
    do_reset();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rst got %0b want 0", halted); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] d;
    do_reset();
    mode = 1'b1; en_b = 1'b1;
    wait_tx(1'b1, 20, ok, d);
    checks++; if (!ok || d !== 8'hFF) begin errors++; $display("FAIL wrap_first got %0h ok=%0b want ff", d, ok); end
    serve(4, 1'b1, d, 1'b1);
    wait_tx(1'b1, 20, ok, d);
    checks++; if (!ok || d !== 8'h00) begin errors++; $display("FAIL wrap_second got %0h ok=%0b want 00", d, ok); end
    checks++; if (pass_cnt_b !== 16'd1) begin errors++; $display("FAIL wrap_pass got %0d want 1", pass_cnt_b); end
    en_b = 1'b0;
    tick(2);
  endtask

  task automatic test_rst_mid();
    bit ok;
    logic [7:0] d;
    int base;
    do_reset();
    mode = 1'b1; en = 1'b1;
    wait_tx(1'b0, 20, ok, d);
    serve(4, 1'b1, d, 1'b0);
    wait_tx(1'b0, 20, ok, d);
    tx_busy = 1'b1;
    tick(4);
    checks++; if (svn !== 4'd3) begin errors++; $display("FAIL rstmid_wait_tx got %0d want 3", svn); end
    checks++; if (pass_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_pre_pass got %0d want 1", pass_cnt); end
    base = txa_cnt;
    rst = 1'b1; en = 1'b0;
    tick(1);
    checks++; if (svn !== 4'd0) begin errors++; $display("FAIL rstmid_idle got %0d want 0", svn); end
    checks++; if (pass_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnts got %0d/%0d want 0/0", pass_cnt, err_cnt); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rstmid_tx_start got %0b want 0", tx_start); end
    rst = 1'b0; tx_busy = 1'b0;
    tick(20);
    checks++; if (txa_cnt !== base) begin errors++; $display("FAIL rstmid_no_tx got %0d want %0d", txa_cnt, base); end
  endtask

  task automatic test_random_echo();
    bit ok;
    logic [7:0] d, b, e;
    int exp_pass;
    do_reset();
    mode = 1'b0; en = 1'b1;
    exp_pass = 0;
    for (int k = 0; k < 6; k++) begin
      tick($urandom_range(2, 20));
      b = 8'($urandom);
      e = b + 8'd1;
      rx_data = b; rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      wait_tx(1'b0, 20, ok, d);
      checks++; if (!ok || d !== e) begin errors++; $display("FAIL recho_%0d got %0h ok=%0b want %0h", k, d, ok, e); end
      exp_pass++;
      tx_busy = 1'b1;
      tick($urandom_range(2, 8));
      tx_busy = 1'b0;
    end
    tick(4);
    checks++; if (pass_cnt !== 16'(exp_pass) || err_cnt !== 16'd0) begin errors++; $display("FAIL recho_cnts got %0d/%0d want %0d/0", pass_cnt, err_cnt, exp_pass); end
    en = 1'b0;
    tick(2);
  endtask

  task automatic test_random_loopback();
    bit ok, wrong, halt_m;
    logic [7:0] d, resp, exp_byte;
    int ep, ee;
    do_reset();
    mode = 1'b1; en = 1'b1;
    exp_byte = 8'd65; ep = 0; ee = 0; halt_m = 1'b0;
    for (int k = 0; k < 8 && !halt_m; k++) begin
      wait_tx(1'b0, 80, ok, d);
      checks++; if (!ok || d !== exp_byte) begin errors++; $display("FAIL rlb_byte%0d got %0h ok=%0b want %0h", k, d, ok, exp_byte); end
      checks++; if (pass_cnt !== 16'(ep) || err_cnt !== 16'(ee)) begin errors++; $display("FAIL rlb_cnts%0d got %0d/%0d want %0d/%0d", k, pass_cnt, err_cnt, ep, ee); end
      wrong = ($urandom_range(0, 3) == 0);
      resp  = wrong ? (exp_byte ^ 8'($urandom_range(1, 255))) : exp_byte;
      serve($urandom_range(2, 12), 1'b1, resp, 1'b0);
      if (wrong) ee++; else ep++;
      exp_byte = exp_byte + 8'd1;
      if (ee >= 2) halt_m = 1'b1;
    end
    tick(4);
    checks++; if (halted !== halt_m) begin errors++; $display("FAIL rlb_halted got %0b want %0b", halted, halt_m); end
    checks++; if (pass_cnt !== 16'(ep) || err_cnt !== 16'(ee)) begin errors++; $display("FAIL rlb_final got %0d/%0d want %0d/%0d", pass_cnt, err_cnt, ep, ee); end
    en = 1'b0;
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback_basic();
    test_echo();
    test_timeout();
    test_halt();
    test_wrap();
    test_rst_mid();
    test_random_echo();
    test_random_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
